key_debounce: RTL and testbench
===============================

KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 SHALL have parameter clk_frequency, default 50000000, input clock frequency in Hz.
REQ-002 SHALL have parameter debounce_ms, default 20, required stable time in ms.
REQ-003 SHALL have parameter active_low, default 1; when 1, raw key level 0 means pressed.
REQ-004 SHALL derive N = (clk_frequency/1000)*debounce_ms, clamped to a minimum of 1; the counter width SHALL be sized to hold N.
REQ-005 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port key_raw  input  4  asynchronous push-button levels.
REQ-008 SHALL have port key_pulse  output  4  one-hot, one-cycle strobe per accepted press; feeds the key input of the lock top.
REQ-009 SHALL have port key_level  output  4  one-hot code of the accepted key, held while the key is down and during release qualification; drives the LEDs.
REQ-010 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-011 SHALL pass each key_raw bit through a 2-flop synchronizer, then invert it if active_low, to form pressed[3:0].
REQ-012 SHALL implement the FSM states IDLE, CONFIRM, HELD and RELEASE; all outputs SHALL be registered.
REQ-013 IDLE: if pressed has exactly one bit set, SHALL latch it as code, clear the counter and go to CONFIRM.
REQ-014 IDLE: if pressed is zero or has two or more bits set, SHALL stay in IDLE, producing no pulse and no count.
REQ-015 CONFIRM: while pressed == code, SHALL increment the counter each cycle.
REQ-016 CONFIRM: in the cycle the counter reaches N-1 with pressed == code, SHALL register key_pulse = code for exactly one cycle and go to HELD.
REQ-017 CONFIRM: any cycle with pressed != code (glitch, release, or an extra key) SHALL return to IDLE with no pulse and code discarded.
REQ-018 Latency: key_pulse SHALL rise N+3 clk edges after the first edge at which key_raw shows a press that stays stable.
REQ-019 HELD: SHALL remain while pressed != 0 and SHALL ignore further keys, including additional simultaneous presses; on pressed == 0 SHALL clear the counter and go to RELEASE.
REQ-020 RELEASE: while pressed == 0, SHALL increment the counter; on reaching N-1 SHALL go to IDLE.
REQ-021 RELEASE: any pressed != 0 SHALL return to HELD with the counter cleared; no new pulse SHALL be generated (bounce on release).
REQ-022 key_level SHALL equal code in HELD and RELEASE, and 0 in IDLE and CONFIRM.
REQ-023 SHALL generate at most one key_pulse per physical press, however long the key is held.
REQ-024 The counter SHALL never wrap; it SHALL saturate at N-1.

Reset
REQ-025 On reset=1 at a clk edge: state SHALL be IDLE; counter and code 0; key_pulse, key_level and busy 0; synchronizer flops SHALL be loaded with the released level (1 if active_low, else 0).
REQ-026 Reset asserted mid-CONFIRM, HELD or RELEASE SHALL abort with no pulse; after release, a key still held SHALL be requalified from IDLE (full N+3 latency).

Verification (clk_frequency=1000, debounce_ms=4, so N=4, active_low=1)
REQ-027 Scenario: key_raw goes from 4'b1111 to 4'b1110 and is held -> key_pulse=4'b0001 for one cycle, 7 edges later; then key_level=4'b0001 and busy=1.
REQ-028 Scenario: key_raw goes to 4'b1101 for 2 cycles, then back to 4'b1111 -> no key_pulse; busy returns to 0.
REQ-029 Scenario: key_raw=4'b1100 (two keys pressed) held for 20 cycles -> no key_pulse, busy stays 0.
REQ-030 Scenario: key 3 is accepted, held for 50 cycles, then released with 1-cycle bounces -> exactly one pulse of 4'b1000; return to IDLE only after 4 clean released cycles.
REQ-031 Scenario: reset is asserted while in HELD with key 2 down -> all outputs are 0 the next edge; after reset deasserts, a second pulse of 4'b0100 occurs 7 edges later.
REQ-032 Scenario: four keys are pressed in turn (0,1,2,3), each cleanly pressed and released -> pulses 0001, 0010, 0100, 1000, in order, one each.

Source files
------------

// File: rtl/key_debounce_if.sv
// Key pad bundle: raw push-button levels in, debounced strobe/level/busy out.
`timescale 1ns/1ps
interface key_debounce_if #(
  parameter int NUM_KEYS = 4
);
  logic [NUM_KEYS-1:0] key_raw;
  logic [NUM_KEYS-1:0] key_pulse;
  logic [NUM_KEYS-1:0] key_level;
  logic                busy;

  modport master (output key_raw, input key_pulse, key_level, busy);
  modport slave  (input key_raw, output key_pulse, key_level, busy);
endinterface

// File: rtl/key_debounce.sv
// Four-key debouncer: per-key 2-flop synchronizer feeding one FSM that accepts a
// single key after a stable press window and requalifies a clean release.
`timescale 1ns/1ps
module key_debounce_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic [1:0] sync_pipe;

  always_ff @(posedge clk) begin
    if (reset) sync_pipe <= {2{RST_VAL}};
    else       sync_pipe <= {sync_pipe[0], d};
  end

  assign q = sync_pipe[1];
endmodule

module key_debounce #(
  parameter int clk_frequency = 50000000,
  parameter int debounce_ms   = 20,
  parameter int active_low    = 1
) (
  input logic           clk,
  input logic           reset,
  key_debounce_if.slave bus
);
  localparam int NUM_KEYS = 4;
  localparam int N_RAW    = (clk_frequency / 1000) * debounce_ms;
  localparam int N        = (N_RAW < 1) ? 1 : N_RAW;
  localparam int CW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(N - 1);
  // Released level of a raw key line; also the synchronizer reset value.
  localparam logic REL    = (active_low != 0) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {IDLE, CONFIRM, HELD, RELEASE} state_t;

  logic [NUM_KEYS-1:0] synced;
  logic [NUM_KEYS-1:0] pressed;
  logic [NUM_KEYS-1:0] code;
  logic [NUM_KEYS-1:0] key_pulse;
  logic [NUM_KEYS-1:0] key_level;
  logic [CW-1:0]       cnt;
  logic                busy;
  state_t              state;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_lane
    key_debounce_sync #(.RST_VAL(REL)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (bus.key_raw[i]),
      .q     (synced[i])
    );
  end

  assign pressed = synced ^ {NUM_KEYS{REL}};

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      code      <= '0;
      key_pulse <= '0;
      key_level <= '0;
      busy      <= 1'b0;
    end else begin
      key_pulse <= '0;
      case (state)
        IDLE: begin
          // Simultaneous presses are never a candidate.
          if ($onehot(pressed)) begin
            code  <= pressed;
            cnt   <= '0;
            state <= CONFIRM;
            busy  <= 1'b1;
          end
        end
        CONFIRM: begin
          if (pressed != code) begin
            code  <= '0;
            state <= IDLE;
            busy  <= 1'b0;
          end else if (cnt == CNT_MAX) begin
            key_pulse <= code;
            key_level <= code;
            state     <= HELD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HELD: begin
          if (pressed == '0) begin
            cnt   <= '0;
            state <= RELEASE;
          end
        end
        RELEASE: begin
          // Any activity here is release bounce: back to HELD, never a new pulse.
          if (pressed != '0) begin
            cnt   <= '0;
            state <= HELD;
          end else if (cnt == CNT_MAX) begin
            code      <= '0;
            key_level <= '0;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          code      <= '0;
          cnt       <= '0;
          key_level <= '0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.key_pulse = key_pulse;
  assign bus.key_level = key_level;
  assign bus.busy      = busy;
endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce (N=4, active low): vector table, corner sequences and
// randomized key activity, all checked against a run-length reference model.
`timescale 1ns/1ps
module tb_key_debounce;
  localparam int N = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  key_debounce_if #(.NUM_KEYS(4)) kif ();

  key_debounce #(
    .clk_frequency (1000),
    .debounce_ms   (4),
    .active_low    (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (kif.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // Reference model: the FSM sees each raw sample two edges late; a key is
  // accepted after N+1 consecutive single-key observations starting from
  // idle, and freed after N+1 consecutive all-released observations.
  logic [3:0] m_s1, m_s2, m_cand, m_acc, m_pulse;
  int         m_run, m_quiet;
  bit         m_engaged;

  task automatic model_step(input logic rst, input logic [3:0] raw);
    logic [3:0] p;
    m_pulse = '0;
    if (rst) begin
      m_s1 = 4'hF; m_s2 = 4'hF; m_cand = '0; m_acc = '0;
      m_run = 0; m_quiet = 0; m_engaged = 0;
      return;
    end
    p = ~m_s2;
    m_s2 = m_s1;
    m_s1 = raw;
    if (m_engaged) begin
      m_quiet = (p == 4'h0) ? m_quiet + 1 : 0;
      if (m_quiet == N + 1) m_engaged = 0;
    end else if (m_cand != 4'h0) begin
      if (p == m_cand) begin
        m_run++;
        if (m_run == N + 1) begin
          m_pulse = m_cand; m_acc = m_cand; m_engaged = 1;
          m_quiet = 0; m_cand = '0;
        end
      end else begin
        m_cand = '0;
      end
    end else if ($countones(p) == 1) begin
      m_cand = p;
      m_run = 1;
    end
  endtask

  int         row_npulse;
  logic [3:0] row_por;

  task automatic tick();
    logic [3:0] exp_level;
    logic       exp_busy;
    @(posedge clk);
    #1;
    model_step(reset, kif.key_raw);
    exp_level = m_engaged ? m_acc : 4'h0;
    exp_busy  = m_engaged || (m_cand != 4'h0);
    check("model", {kif.key_pulse, kif.key_level, kif.busy}, {m_pulse, exp_level, exp_busy});
    if (kif.key_pulse != 4'h0) begin
      row_npulse++;
      row_por |= kif.key_pulse;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Drives until the first pulse; returns edges taken (0 if none within 20).
  task automatic measure_latency(output int lat, output logic [3:0] pv);
    lat = 0; pv = '0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (kif.key_pulse != 4'h0) begin
        lat = i; pv = kif.key_pulse;
        break;
      end
    end
  endtask

  typedef struct {
    logic [3:0] raw;
    logic       rst;
    int         cyc;
    int         npulse;
    logic [3:0] por;
    logic [3:0] level;
    logic       busy;
  } vec_t;

  vec_t vt[$];

  initial begin
    int         lat;
    logic [3:0] pv;

    vt.push_back('{4'hF, 0,  5, 0, 4'h0, 4'h0, 0});
    vt.push_back('{4'hE, 0, 10, 1, 4'h1, 4'h1, 1}); // key 0 accepted
    vt.push_back('{4'hF, 0, 10, 0, 4'h0, 4'h0, 0});
    vt.push_back('{4'hD, 0,  2, 0, 4'h0, 4'h0, 0}); // short glitch
    vt.push_back('{4'hF, 0, 10, 0, 4'h0, 4'h0, 0});
    vt.push_back('{4'hC, 0, 20, 0, 4'h0, 4'h0, 0}); // two keys
    vt.push_back('{4'hF, 0,  5, 0, 4'h0, 4'h0, 0});
    vt.push_back('{4'h7, 0, 10, 1, 4'h8, 4'h8, 1}); // key 3
    vt.push_back('{4'h7, 0, 50, 0, 4'h0, 4'h8, 1});
    vt.push_back('{4'hF, 0,  1, 0, 4'h0, 4'h8, 1}); // release bounces
    vt.push_back('{4'h7, 0,  1, 0, 4'h0, 4'h8, 1});
    vt.push_back('{4'hF, 0,  1, 0, 4'h0, 4'h8, 1});
    vt.push_back('{4'h7, 0,  1, 0, 4'h0, 4'h8, 1});
    vt.push_back('{4'hF, 0,  6, 0, 4'h0, 4'h8, 1}); // one quiet cycle short
    vt.push_back('{4'hF, 0,  1, 0, 4'h0, 4'h0, 0});
    vt.push_back('{4'hE, 0, 10, 1, 4'h1, 4'h1, 1}); // keys in turn
    vt.push_back('{4'hF, 0, 10, 0, 4'h0, 4'h0, 0});
    vt.push_back('{4'hD, 0, 10, 1, 4'h2, 4'h2, 1});
    vt.push_back('{4'hF, 0, 10, 0, 4'h0, 4'h0, 0});
    vt.push_back('{4'hB, 0, 10, 1, 4'h4, 4'h4, 1});
    vt.push_back('{4'hF, 0, 10, 0, 4'h0, 4'h0, 0});
    vt.push_back('{4'h7, 0, 10, 1, 4'h8, 4'h8, 1});
    vt.push_back('{4'hF, 0, 10, 0, 4'h0, 4'h0, 0});
    vt.push_back('{4'hB, 1,  3, 0, 4'h0, 4'h0, 0}); // reset with key down
    vt.push_back('{4'hB, 0, 10, 1, 4'h4, 4'h4, 1}); // requalified
    vt.push_back('{4'hF, 0, 10, 0, 4'h0, 4'h0, 0});

    kif.key_raw = 4'hF;
    reset = 1'b1;
    ticks(3);
    check("reset_out", {kif.key_pulse, kif.key_level, kif.busy}, 9'h0);
    reset = 1'b0;

    foreach (vt[r]) begin
      kif.key_raw = vt[r].raw;
      reset       = vt[r].rst;
      row_npulse  = 0;
      row_por     = '0;
      ticks(vt[r].cyc);
      check($sformatf("row%0d_npulse", r), row_npulse, vt[r].npulse);
      check($sformatf("row%0d_pulse", r), row_por, vt[r].por);
      check($sformatf("row%0d_level", r), kif.key_level, vt[r].level);
      check($sformatf("row%0d_busy", r), kif.busy, vt[r].busy);
    end
    reset = 1'b0;

    // Press latency from the first sampling edge.
    kif.key_raw = 4'hE;
    measure_latency(lat, pv);
    check("latency", lat, 7);
    check("latency_code", pv, 4'h1);
    kif.key_raw = 4'hF;
    ticks(10);

    // Reset while HELD, then requalification of the still-held key.
    kif.key_raw = 4'hB;
    ticks(10);
    check("held_level", kif.key_level, 4'h4);
    reset = 1'b1;
    tick();
    check("rst_held_out", {kif.key_pulse, kif.key_level, kif.busy}, 9'h0);
    reset = 1'b0;
    measure_latency(lat, pv);
    check("rst_relatency", lat, 7);
    check("rst_recode", pv, 4'h4);
    kif.key_raw = 4'hF;
    ticks(10);

    // Randomized key activity, occasional resets.
    for (int s = 0; s < 250; s++) begin
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 4)       kif.key_raw = ~(4'h1 << sel);
      else if (sel < 7)  kif.key_raw = 4'hF;
      else               kif.key_raw = 4'($urandom_range(0, 15));
      reset = ($urandom_range(0, 39) == 0);
      ticks(reset ? 1 : $urandom_range(1, 12));
    end
    reset = 1'b0;
    kif.key_raw = 4'hF;
    ticks(12);
    check("final_idle", {kif.key_level, kif.busy}, 5'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
